// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain for one LEGv8 stage boundary: DEPTH slots of
// {valid, ctrl, data} with back-pressure, bubble collapse, flush and NOP bubbles.
module pipe_stage_chain #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 13,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH:0]    rdy_s;
  logic [DEPTH-1:0]  v_r;
  logic [DEPTH-1:0]  v_nxt_s;
  logic [CTRL_W-1:0] ctrl_r     [DEPTH];
  logic [CTRL_W-1:0] ctrl_nxt_s [DEPTH];
  logic [DATA_W-1:0] data_r     [DEPTH];
  logic [DATA_W-1:0] data_nxt_s [DEPTH];
  logic [CNT_W-1:0]  count_r;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [CNT_W-1:0] sum;
    sum = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + CNT_W'(bits[i]);
    end
    return sum;
  endfunction

  // Ready chain: a slot can load if any slot from it to the output is empty,
  // or the consumer is taking the last entry.
  always_comb begin
    logic acc_s;
    acc_s = out_ready;
    rdy_s = {(DEPTH + 1){1'b0}};
    rdy_s[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc_s = ~v_r[i] | acc_s;
      rdy_s[i] = acc_s;
    end
  end

  assign in_ready = rdy_s[0] & ~flush;

  // Next-state for every slot; flush kills valid/ctrl but leaves data untouched.
  always_comb begin
    v_nxt_s    = v_r;
    ctrl_nxt_s = ctrl_r;
    data_nxt_s = data_r;
    if (flush) begin
      v_nxt_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_nxt_s[i] = {CTRL_W{1'b0}};
      end
    end else begin
      if (rdy_s[0]) begin
        v_nxt_s[0]    = in_valid;
        ctrl_nxt_s[0] = in_valid ? in_ctrl : {CTRL_W{1'b0}};
        data_nxt_s[0] = in_data;
      end else begin
        v_nxt_s[0]    = v_r[0];
        ctrl_nxt_s[0] = ctrl_r[0];
        data_nxt_s[0] = data_r[0];
      end
      // Downstream slots shift forward when their ready is set; an invalid
      // source carries a NOP control field but its data rides along.
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy_s[i]) begin
          v_nxt_s[i]    = v_r[i-1];
          ctrl_nxt_s[i] = v_r[i-1] ? ctrl_r[i-1] : {CTRL_W{1'b0}};
          data_nxt_s[i] = data_r[i-1];
        end else begin
          v_nxt_s[i]    = v_r[i];
          ctrl_nxt_s[i] = ctrl_r[i];
          data_nxt_s[i] = data_r[i];
        end
      end
    end
  end

  // Slot and occupancy registers; reset drops every entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r     <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_r[i] <= {CTRL_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      v_r     <= v_nxt_s;
      count_r <= popcount(v_nxt_s);
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_r[i] <= ctrl_nxt_s[i];
        data_r[i] <= data_nxt_s[i];
      end
    end
  end

  assign out_valid = v_r[DEPTH-1];
  assign out_ctrl  = ctrl_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];
  assign count     = count_r;

endmodule
